// File: rtl/nrf_seq_pkg.sv
// ============================================================================
// nrf_seq_pkg : nRF24L01 opcodes, register map, init table and sequencer states
// Rev 1.0
// ============================================================================
`default_nettype none

package nrf_seq_pkg;

   localparam logic [7:0] OP_W_REGISTER   = 8'h20;
   localparam logic [7:0] OP_W_TX_PAYLOAD = 8'hA0;
   localparam logic [7:0] OP_FLUSH_TX     = 8'hE1;

   localparam logic [7:0] REG_CONFIG    = 8'h00;
   localparam logic [7:0] REG_EN_AA     = 8'h01;
   localparam logic [7:0] REG_RF_CH     = 8'h05;
   localparam logic [7:0] REG_RF_SETUP  = 8'h06;
   localparam logic [7:0] REG_RX_PW_P0  = 8'h11;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] val;
   } init_entry_t;

   localparam int INIT_LEN       = 5;
   localparam int INIT_RX_PW_IDX = 4;

   // RX_PW_P0 value is replaced by the payload length when the byte is issued
   localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
      '{REG_CONFIG,   8'h0E},
      '{REG_EN_AA,    8'h00},
      '{REG_RF_CH,    8'h4C},
      '{REG_RF_SETUP, 8'h06},
      '{REG_RX_PW_P0, 8'h00}
   };

   typedef enum logic [2:0] {
      ST_POR_WAIT = 3'd0,
      ST_CFG      = 3'd1,
      ST_IDLE     = 3'd2,
      ST_PAY      = 3'd3,
      ST_CE       = 3'd4,
      ST_FAULT    = 3'd5
`ifdef NRF_TX_SEQ_FLUSH_EN
      ,
      ST_FLUSH    = 3'd6
`endif
   } seq_state_e;

   function automatic logic [7:0] init_byte(input logic [3:0] idx, input logic [7:0] plen);
      init_entry_t e;
      e = INIT_TABLE[idx[3:1]];
      if (idx[3:1] == 3'(INIT_RX_PW_IDX)) e.val = plen;
      return idx[0] ? e.val : (OP_W_REGISTER | e.addr);
   endfunction

endpackage

`default_nettype wire

// File: rtl/nrf_ce_pulse.sv
// ============================================================================
// nrf_ce_pulse : holds CE high for CE_PULSE_CYC cycles after a start strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module nrf_ce_pulse #(
   parameter int CE_PULSE_CYC = 150
) (
   input  logic clk_10,
   input  logic rst,
   input  logic start_i,
   output logic ce_o,
   output logic last_o,
   output logic end_o
);

   localparam int CNT_W = $clog2(CE_PULSE_CYC + 1);
   localparam logic [CNT_W-1:0] C_CNT_END = CNT_W'(CE_PULSE_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             ce_q;
   logic             end_q;

   // Final high cycle of CE; lets the sequencer leave CE in step with the fall
   assign last_o = ce_q && (cnt_q == C_CNT_END);
   assign ce_o   = ce_q;
   assign end_o  = end_q;

   always_ff @(posedge clk_10) begin
      if (rst) begin
         cnt_q <= '0;
         ce_q  <= 1'b0;
         end_q <= 1'b0;
      end else begin
         end_q <= last_o;
         if (start_i) begin
            ce_q  <= 1'b1;
            cnt_q <= '0;
         end else if (last_o) begin
            ce_q  <= 1'b0;
            cnt_q <= '0;
         end else if (ce_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/nrf_tx_sequencer.sv
// ============================================================================
// nrf_tx_sequencer : nRF24L01 init-table writer and W_TX_PAYLOAD/CE launcher
// Optional FLUSH_TX before each packet: define NRF_TX_SEQ_FLUSH_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module nrf_tx_sequencer
   import nrf_seq_pkg::*;
#(
   parameter int PAYLOAD_LEN  = 4,
   parameter int POR_CYC      = 1000,
   parameter int CE_PULSE_CYC = 150,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic                     clk_10,
   input  logic                     rst,
   input  logic                     send,
   input  logic [8*PAYLOAD_LEN-1:0] payload_in,
   output logic                     ready,
   output logic                     done,
   output logic                     error,
   output logic [7:0]               spi_data_in,
   output logic                     spi_start_tx,
   output logic                     spi_last,
   input  logic                     spi_done_tx,
   output logic                     ce_tx
);

   localparam int POR_W = $clog2(POR_CYC + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [POR_W-1:0] C_POR_END  = POR_W'(POR_CYC - 1);
   localparam logic [TMO_W-1:0] C_TMO_END  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [5:0]       C_CFG_LAST = 6'(2 * INIT_LEN - 1);
   localparam logic [5:0]       C_PAY_LAST = 6'(PAYLOAD_LEN);
   localparam logic [7:0]       C_PLEN     = 8'(PAYLOAD_LEN);

   seq_state_e               state_q, state_d;
   logic [POR_W-1:0]         por_cnt_q, por_cnt_d;
   logic [TMO_W-1:0]         tmo_q, tmo_d;
   logic [5:0]               idx_q, idx_d;
   logic                     out_q, out_d;
   logic [7:0]               data_q, data_d;
   logic                     last_q, last_d;
   logic                     start_q, start_d;
   logic                     err_q, err_d;
   logic                     ready_q;
   logic [8*PAYLOAD_LEN-1:0] payload_q;

   logic       w_capture;
   logic       w_ce_start;
   logic       w_ce_last;
   logic       w_ce;
   logic       w_ce_end;
   logic [5:0] w_issue_idx;
   logic [5:0] w_pay_sel;
   logic [7:0] w_pay_byte;
   logic [7:0] w_byte;
   logic       w_byte_last;
   logic       w_final;
   seq_state_e w_frame_next;

   // Byte to issue: the current index when idle, the next one when chaining on done
   always_comb begin
      w_issue_idx  = out_q ? (idx_q + 6'd1) : idx_q;
      w_pay_sel    = w_issue_idx - 6'd1;
      w_pay_byte   = 8'(payload_q >> {w_pay_sel, 3'b000});
      w_byte       = 8'h00;
      w_byte_last  = 1'b0;
      w_final      = 1'b0;
      w_frame_next = state_q;
      case (state_q)
         ST_CFG: begin
            w_byte       = init_byte(w_issue_idx[3:0], C_PLEN);
            w_byte_last  = w_issue_idx[0];
            w_final      = (idx_q == C_CFG_LAST);
            w_frame_next = ST_IDLE;
         end
         ST_PAY: begin
            w_byte       = (w_issue_idx == 6'd0) ? OP_W_TX_PAYLOAD : w_pay_byte;
            w_byte_last  = (w_issue_idx == C_PAY_LAST);
            w_final      = (idx_q == C_PAY_LAST);
            w_frame_next = ST_CE;
         end
`ifdef NRF_TX_SEQ_FLUSH_EN
         ST_FLUSH: begin
            w_byte       = OP_FLUSH_TX;
            w_byte_last  = 1'b1;
            w_final      = 1'b1;
            w_frame_next = ST_PAY;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      por_cnt_d  = por_cnt_q;
      tmo_d      = tmo_q;
      idx_d      = idx_q;
      out_d      = out_q;
      data_d     = data_q;
      last_d     = last_q;
      start_d    = 1'b0;
      err_d      = err_q;
      w_capture  = 1'b0;
      w_ce_start = 1'b0;
      case (state_q)
         ST_POR_WAIT: begin
            if (por_cnt_q == C_POR_END) begin
               state_d   = ST_CFG;
               por_cnt_d = '0;
            end else begin
               por_cnt_d = por_cnt_q + POR_W'(1);
            end
         end
         ST_IDLE: begin
            if (send) begin
               w_capture = 1'b1;
               idx_d     = 6'd0;
               out_d     = 1'b0;
`ifdef NRF_TX_SEQ_FLUSH_EN
               state_d   = ST_FLUSH;
`else
               state_d   = ST_PAY;
`endif
            end
         end
         ST_CE: begin
            if (w_ce_last) state_d = ST_IDLE;
         end
         ST_FAULT: ;
         default: begin
            if (!out_q) begin
               start_d = 1'b1;
               out_d   = 1'b1;
               tmo_d   = '0;
               data_d  = w_byte;
               last_d  = w_byte_last;
            end else if (spi_done_tx) begin
               if (w_final) begin
                  out_d      = 1'b0;
                  idx_d      = 6'd0;
                  state_d    = w_frame_next;
                  w_ce_start = (w_frame_next == ST_CE);
               end else begin
                  idx_d   = w_issue_idx;
                  start_d = 1'b1;
                  tmo_d   = '0;
                  data_d  = w_byte;
                  last_d  = w_byte_last;
               end
            end else if (tmo_q == C_TMO_END) begin
               out_d   = 1'b0;
               err_d   = 1'b1;
               state_d = ST_FAULT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_10) begin
      if (rst) begin
         state_q   <= ST_POR_WAIT;
         por_cnt_q <= '0;
         tmo_q     <= '0;
         idx_q     <= 6'd0;
         out_q     <= 1'b0;
         data_q    <= 8'h00;
         last_q    <= 1'b0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
         ready_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         state_q   <= state_d;
         por_cnt_q <= por_cnt_d;
         tmo_q     <= tmo_d;
         idx_q     <= idx_d;
         out_q     <= out_d;
         data_q    <= data_d;
         last_q    <= last_d;
         start_q   <= start_d;
         err_q     <= err_d;
         ready_q   <= (state_d == ST_IDLE);
         if (w_capture) payload_q <= payload_in;
      end
   end

   nrf_ce_pulse #(
      .CE_PULSE_CYC (CE_PULSE_CYC)
   ) u_ce_pulse (
      .clk_10  (clk_10),
      .rst     (rst),
      .start_i (w_ce_start),
      .ce_o    (w_ce),
      .last_o  (w_ce_last),
      .end_o   (w_ce_end)
   );

   assign ready        = ready_q;
   assign done         = w_ce_end;
   assign error        = err_q;
   assign spi_data_in  = data_q;
   assign spi_start_tx = start_q;
   assign spi_last     = last_q;
   assign ce_tx        = w_ce;

endmodule

`default_nettype wire

// File: tb/tb_nrf_tx_sequencer.sv
// ============================================================================
// tb_nrf_tx_sequencer : directed bench with a byte-level SPI responder model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nrf_tx_sequencer;

   localparam int PAYLOAD_LEN  = 4;
   localparam int POR_CYC      = 1000;
   localparam int CE_PULSE_CYC = 150;
   localparam int TIMEOUT_CYC  = 255;
   localparam int RSP_DLY      = 80;

   localparam logic [7:0] CFG_EXP [10] = '{8'h20, 8'h0E, 8'h21, 8'h00, 8'h25,
                                           8'h4C, 8'h26, 8'h06, 8'h31, 8'h04};
`ifdef NRF_TX_SEQ_FLUSH_EN
   localparam int PKT_N = 6;
   localparam logic [7:0] PKT_EXP [6] = '{8'hE1, 8'hA0, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
   localparam logic       PKT_LST [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
   localparam int PKT_N = 5;
   localparam logic [7:0] PKT_EXP [5] = '{8'hA0, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
   localparam logic       PKT_LST [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

   logic        clk_10 = 1'b0;
   logic        rst = 1'b1;
   logic        send = 1'b0;
   logic [31:0] payload_in = 32'h0;
   logic        spi_done_tx = 1'b0;
   logic        ready, done, error, spi_start_tx, spi_last, ce_tx;
   logic [7:0]  spi_data_in;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   // responder state (written only by the responder process)
   logic [7:0] log_data [$];
   logic       log_last [$];
   int         log_cyc  [$];
   int         cd = 0;
   int         done_drv_cyc = 0;
   int         done_cnt = 0;

   // stimulus state (written only by the main initial block)
   int drop_idx = -1;
   int rel_cyc = 0;
   int log_base = 0;
   int pkt_base = 0;
   int send_cyc = 0;

   always #5 clk_10 = ~clk_10;
   always @(posedge clk_10) cyc <= cyc + 1;

   nrf_tx_sequencer #(
      .PAYLOAD_LEN  (PAYLOAD_LEN),
      .POR_CYC      (POR_CYC),
      .CE_PULSE_CYC (CE_PULSE_CYC),
      .TIMEOUT_CYC  (TIMEOUT_CYC)
   ) dut (
      .clk_10       (clk_10),
      .rst          (rst),
      .send         (send),
      .payload_in   (payload_in),
      .ready        (ready),
      .done         (done),
      .error        (error),
      .spi_data_in  (spi_data_in),
      .spi_start_tx (spi_start_tx),
      .spi_last     (spi_last),
      .spi_done_tx  (spi_done_tx),
      .ce_tx        (ce_tx)
   );

   // SPI stage: answers each start RSP_DLY cycles later unless told to drop it
   always @(negedge clk_10) begin
      spi_done_tx = 1'b0;
      if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            spi_done_tx  = 1'b1;
            done_drv_cyc = cyc;
         end
      end
      if (spi_start_tx === 1'b1) begin
         if (log_data.size() != drop_idx) cd = RSP_DLY;
         log_data.push_back(spi_data_in);
         log_last.push_back(spi_last);
         log_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // kind 0: ready, 1: ce_tx, 2: done, 3: log holds at least arg bytes
   task automatic wait_for(input int kind, input int arg, input int budget, input string tag);
      int  n;
      bit  hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clk_10);
         n = n + 1;
         case (kind)
            0:       hit = (ready === 1'b1);
            1:       hit = (ce_tx === 1'b1);
            2:       hit = (done === 1'b1);
            default: hit = (log_data.size() >= arg);
         endcase
      end
      if (!hit) chk({tag, "_wait"}, 32'(0), 32'(1));
   endtask

   task automatic assert_rst(input string tag);
      @(negedge clk_10);
      rst  = 1'b1;
      send = 1'b0;
      @(negedge clk_10);
      chk({tag, "_ce"},    32'(ce_tx),        32'(0));
      chk({tag, "_ready"}, 32'(ready),        32'(0));
      chk({tag, "_start"}, 32'(spi_start_tx), 32'(0));
      chk({tag, "_done"},  32'(done),         32'(0));
   endtask

   task automatic release_rst();
      repeat (2) @(negedge clk_10);
      rst      = 1'b0;
      rel_cyc  = cyc;
      log_base = log_data.size();
   endtask

   task automatic check_cfg(input string tag);
      int ready_cyc;
      wait_for(0, 0, 3000, {tag, "_ready"});
      ready_cyc = cyc;
      chk({tag, "_count"}, 32'(log_data.size() - log_base), 32'(10));
      for (int i = 0; i < 10; i++) begin
         if (log_base + i < log_data.size()) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(log_data[log_base + i]), 32'(CFG_EXP[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(log_last[log_base + i]), 32'(i % 2));
         end
      end
      if (log_data.size() > log_base)
         chk({tag, "_first_start_cyc"}, 32'(log_cyc[log_base] - rel_cyc), 32'(POR_CYC + 1));
      chk({tag, "_ready_lat"}, 32'(ready_cyc - done_drv_cyc), 32'(1));
      chk({tag, "_error"}, 32'(error), 32'(0));
   endtask

   task automatic send_pkt(input logic [31:0] pl);
      @(negedge clk_10);
      payload_in = pl;
      send       = 1'b1;
      send_cyc   = cyc;
      pkt_base   = log_data.size();
      @(negedge clk_10);
      send       = 1'b0;
      payload_in = 32'h55667788;
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ce_cyc;
      int done_base;
      int s;

      // ---- reset values and config table, with an ignored send during CFG ----
      repeat (3) @(negedge clk_10);
      chk("rst_ready", 32'(ready),        32'(0));
      chk("rst_done",  32'(done),         32'(0));
      chk("rst_error", 32'(error),        32'(0));
      chk("rst_data",  32'(spi_data_in),  32'(0));
      chk("rst_start", 32'(spi_start_tx), 32'(0));
      chk("rst_last",  32'(spi_last),     32'(0));
      chk("rst_ce",    32'(ce_tx),        32'(0));
      release_rst();
      wait_for(3, log_base + 3, 2000, "cfg_mid");
      @(negedge clk_10);
      send       = 1'b1;
      payload_in = 32'h11223344;
      @(negedge clk_10);
      send       = 1'b0;
      check_cfg("cfg");
      chk("cfg_no_done", 32'(done_cnt), 32'(0));

      // ---- packet send, second send during CE is ignored ----
      done_base = done_cnt;
      send_pkt(32'hDDCCBBAA);
      wait_for(1, 0, 1000, "pkt_ce");
      ce_cyc = cyc;
      chk("pkt_ce_rise_lat", 32'(ce_cyc - done_drv_cyc), 32'(1));
      @(negedge clk_10);
      send = 1'b1;
      @(negedge clk_10);
      send = 1'b0;
      wait_for(2, 0, 400, "pkt_done");
      chk("pkt_ce_len",     32'(cyc - ce_cyc), 32'(CE_PULSE_CYC));
      chk("pkt_ce_fall",    32'(ce_tx),        32'(0));
      chk("pkt_ready_back", 32'(ready),        32'(1));
      repeat (200) @(negedge clk_10);
      chk("pkt_count", 32'(log_data.size() - pkt_base), 32'(PKT_N));
      for (int i = 0; i < PKT_N; i++) begin
         if (pkt_base + i < log_data.size()) begin
            chk($sformatf("pkt_byte%0d", i), 32'(log_data[pkt_base + i]), 32'(PKT_EXP[i]));
            chk($sformatf("pkt_last%0d", i), 32'(log_last[pkt_base + i]), 32'(PKT_LST[i]));
         end
      end
      if (log_data.size() > pkt_base)
         chk("pkt_start_lat", 32'(log_cyc[pkt_base] - send_cyc), 32'(2));
      chk("pkt_done_count", 32'(done_cnt - done_base), 32'(1));

      // ---- reset during the 2nd payload byte ----
      send_pkt(32'h04030201);
      wait_for(3, pkt_base + PKT_N - 2, 1500, "rmid_pay");
      assert_rst("rmid_pay");
      release_rst();
      check_cfg("rcfg1");

      // ---- reset during the CE pulse ----
      done_base = done_cnt;
      send_pkt(32'h0A0B0C0D);
      wait_for(1, 0, 1000, "rmid_ce");
      repeat (20) @(negedge clk_10);
      assert_rst("rmid_ce");
      release_rst();
      check_cfg("rcfg2");
      chk("rmid_ce_no_done", 32'(done_cnt - done_base), 32'(0));

      // ---- timeout on the 3rd config byte ----
      @(negedge clk_10);
      rst = 1'b1;
      drop_idx = log_data.size() + 2;
      release_rst();
      wait_for(3, log_base + 3, 2000, "tmo_start");
      s = (log_data.size() >= log_base + 3) ? log_cyc[log_base + 2] : cyc;
      while (cyc < s + TIMEOUT_CYC - 1) @(negedge clk_10);
      chk("tmo_err_before", 32'(error), 32'(0));
      @(negedge clk_10);
      chk("tmo_err_at", 32'(error), 32'(1));
      send = 1'b1;
      @(negedge clk_10);
      send = 1'b0;
      repeat (400) @(negedge clk_10);
      chk("tmo_no_traffic", 32'(log_data.size() - log_base), 32'(3));
      chk("tmo_ce",         32'(ce_tx), 32'(0));
      chk("tmo_err_sticky", 32'(error), 32'(1));
      chk("tmo_ready",      32'(ready), 32'(0));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
